fft_bitrev_reorder: RTL and testbench



---
 rtl/fft_pkg.sv | 39 +++
 rtl/fft_reorder_ram.sv | 47 ++++
 rtl/fft_bitrev_reorder.sv | 156 +++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT64 output path: frame constants, the
// bit-reversal helper used to map FFT output order to natural order, the
// complex sample type and the reorder reader state encoding.
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_N     = 64;
  localparam int FFT_LOG2N = 6;
  localparam int FFT_WIDTH = 16;

  typedef struct packed {
    logic [FFT_WIDTH-1:0] re;
    logic [FFT_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

  // Reverses the low log2n bits of value; upper result bits are zero.
  // log2n must be a constant at every synthesized call site.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int log2n);
    logic [31:0] v;
    logic [31:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < log2n) begin
        r = {r[30:0], v[0]};
        v = {1'b0, v[31:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// -----------------------------------------------------------------------------
// fft_reorder_ram
// Simple dual-port RAM backing the reorder ping-pong buffer. The address is
// {bank, index}. One synchronous write port, one registered read port whose
// output register holds its value when no read is issued.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset (clears read register only)
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable
//   raddr_i  : read address
//   rdata_o  : registered read data (valid the cycle after re_i)
// -----------------------------------------------------------------------------
module fft_reorder_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read register is cleared on reset so the block outputs start at zero;
  // the array itself is never cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
// Streaming reorder buffer behind FFT64. Samples arrive in bit-reversed order
// and are written to address bitrev(wcnt) of the filling bank; the draining
// bank is read linearly, so each frame leaves in natural bin order 0..N-1.
// Two banks ping-pong so back-to-back frames flow without stalls.
//
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-high reset
//   di_en  : input sample valid
//   di_re  : input real part (bit-reversed order)
//   di_im  : input imaginary part
//   do_en  : output sample valid
//   do_re  : output real part (natural order), holds when do_en=0
//   do_im  : output imaginary part, holds when do_en=0
//   do_sof : high with the bin-0 word of each output frame
//   ovf    : sticky flag, set when a write lands in a bank still awaiting drain
// -----------------------------------------------------------------------------
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int WIDTH = FFT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_sof,
  output logic             ovf
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;
  logic [1:0]       full_q, full_d;
  rd_state_e        state_q, state_d;
  logic             ovf_q, ovf_d;
  logic             do_en_q, do_sof_q;

  logic             wr_last;
  logic [1:0]       full_set, full_clr;
  logic             rd_en;
  logic [LOG2N-1:0] waddr;
  logic [2*WIDTH-1:0] rdata;

  // Write side: scatter into the filling bank at the bit-reversed index.
  assign wr_last = di_en && (wcnt_q == LAST);
  assign waddr   = LOG2N'(bitrev(32'(wcnt_q), LOG2N));

  always_comb begin
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    full_set = '0;
    if (di_en) begin
      wcnt_d = wr_last ? '0 : wcnt_q + 1'b1;
    end
    if (wr_last) begin
      full_set[wbank_q] = 1'b1;
      wbank_d           = ~wbank_q;
    end
  end

  // Read side: drain a full bank linearly; chain straight into the other bank
  // when it is already full so consecutive frames have no idle cycle.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    rbank_d  = rbank_q;
    full_clr = '0;
    rd_en    = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = RD_READ;
          rcnt_d  = '0;
        end
      end
      RD_READ: begin
        rd_en  = 1'b1;
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == LAST) begin
          full_clr[rbank_q] = 1'b1;
          rbank_d           = ~rbank_q;
          if (full_q[~rbank_q]) begin
            state_d = RD_READ;
            rcnt_d  = '0;
          end else begin
            state_d = RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Set wins over clear for the same bank. A write into a bank that the reader
  // is releasing on this very edge is not an overflow: the drain is complete.
  assign full_d = (full_q & ~full_clr) | full_set;
  assign ovf_d  = ovf_q | (di_en & full_q[wbank_q] & ~full_clr[wbank_q]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt_q   <= '0;
      wbank_q  <= 1'b0;
      rcnt_q   <= '0;
      rbank_q  <= 1'b0;
      full_q   <= '0;
      state_q  <= RD_IDLE;
      ovf_q    <= 1'b0;
      do_en_q  <= 1'b0;
      do_sof_q <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      wbank_q  <= wbank_d;
      rcnt_q   <= rcnt_d;
      rbank_q  <= rbank_d;
      full_q   <= full_d;
      state_q  <= state_d;
      ovf_q    <= ovf_d;
      // Output stage: flags aligned with the registered RAM read.
      do_en_q  <= rd_en;
      do_sof_q <= rd_en && (rcnt_q == '0);
    end
  end

  fft_reorder_ram #(
    .AW(LOG2N + 1),
    .DW(2 * WIDTH)
  ) u_ram (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (di_en),
    .waddr_i ({wbank_q, waddr}),
    .wdata_i ({di_re, di_im}),
    .re_i    (rd_en),
    .raddr_i ({rbank_q, rcnt_q}),
    .rdata_o (rdata)
  );

  assign do_en  = do_en_q;
  assign do_sof = do_sof_q;
  assign do_re  = rdata[2*WIDTH-1:WIDTH];
  assign do_im  = rdata[WIDTH-1:0];
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

  localparam int N     = 64;
  localparam int LOG2N = 6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, di_en;
  logic [15:0] di_re, di_im;
  logic        do_en, do_sof, ovf;
  logic [15:0] do_re, do_im;

  logic        rst8, d8_en;
  logic [15:0] d8_re, d8_im;
  logic        o8_en, o8_sof, o8_ovf;
  logic [15:0] o8_re, o8_im;

  fft_bitrev_reorder dut (
    .clock (clock), .reset (reset),
    .di_en (di_en), .di_re (di_re), .di_im (di_im),
    .do_en (do_en), .do_re (do_re), .do_im (do_im),
    .do_sof(do_sof), .ovf (ovf)
  );

  fft_bitrev_reorder #(.N(8), .LOG2N(3), .WIDTH(16)) dut8 (
    .clock (clock), .reset (rst8),
    .di_en (d8_en), .di_re (d8_re), .di_im (d8_im),
    .do_en (o8_en), .do_re (o8_re), .do_im (o8_im),
    .do_sof(o8_sof), .ovf (o8_ovf)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        sof;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int run = 0;
  int last_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reverse the low 'bits' digits of v in base 2.
  function automatic int rev(input int v, input int bits);
    int r = 0;
    int x = v;
    for (int i = 0; i < bits; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      run = 0;
    end else if (do_en) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: do_en=1 with re=%0d im=%0d but nothing expected", do_re, do_im);
      end else begin
        e = sbq.pop_front();
        chk("out_re", 32'(do_re), 32'(e.re));
        chk("out_im", 32'(do_im), 32'(e.im));
        chk("out_sof", 32'(do_sof), 32'(e.sof));
      end
      run++;
    end else begin
      if (run != 0) begin
        chk("burst_whole_frames", 32'(run % N), 0);
        last_run = run;
      end
      run = 0;
    end
  end

  // Sends one frame (arrival order = FFT bit-reversed order). gap_mode:
  // 0 continuous, 1 alternate idle cycles, 2 random idle cycles.
  // Stops before sample stop_at without queuing expectations if stop_at < N.
  task automatic send_frame(input bit pattern, input int gap_mode, input int stop_at);
    logic [15:0] fre[N];
    logic [15:0] fim[N];
    exp_t e;
    for (int k = 0; k < N; k++) begin
      if (k == stop_at) return;
      fre[k] = pattern ? 16'(k) : 16'($urandom);
      fim[k] = pattern ? 16'(N - 1 - k) : 16'($urandom);
      di_en = 1'b1;
      di_re = fre[k];
      di_im = fim[k];
      @(posedge clock); #1;
      if (k < N - 1 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
        di_en = 1'b0;
        di_re = 16'($urandom);
        @(posedge clock); #1;
      end
    end
    // Natural bin n is the sample that arrived at position bitrev(n).
    for (int n = 0; n < N; n++) begin
      e.re  = fre[rev(n, LOG2N)];
      e.im  = fim[rev(n, LOG2N)];
      e.sof = (n == 0);
      sbq.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while (sbq.size() != 0 && c < 1000) begin
      @(posedge clock);
      c++;
    end
    chk({name, "_drained"}, 32'(sbq.size()), 0);
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; di_en = 1'b0; di_re = '0; di_im = '0;
    rst8  = 1'b1; d8_en = 1'b0; d8_re = '0; d8_im = '0;
    #100;
    chk("rst_do_en", 32'(do_en), 0);
    chk("rst_do_sof", 32'(do_sof), 0);
    chk("rst_do_re", 32'(do_re), 0);
    chk("rst_do_im", 32'(do_im), 0);
    chk("rst_ovf", 32'(ovf), 0);
    #2;
    reset = 1'b0;
    rst8  = 1'b0;
    @(posedge clock); #1;

    // Single deterministic frame with latency check.
    send_frame(1'b1, 0, N);
    di_en = 1'b0;
    @(posedge clock); #1;
    chk("latency_edge1_idle", 32'(do_en), 0);
    @(posedge clock); #1;
    chk("latency_edge2_valid", 32'(do_en), 1);
    chk("latency_edge2_sof", 32'(do_sof), 1);
    chk("latency_edge2_re", 32'(do_re), 0);
    wait_drain("single");
    chk("single_burst_len", 32'(last_run), 64);

    // Gapped input, alternating then random.
    send_frame(1'b1, 1, N);
    di_en = 1'b0;
    wait_drain("gapped");
    chk("gapped_burst_len", 32'(last_run), 64);
    send_frame(1'b0, 2, N);
    di_en = 1'b0;
    wait_drain("randgap");
    chk("randgap_burst_len", 32'(last_run), 64);

    // Three frames back to back.
    for (int f = 0; f < 3; f++) send_frame(1'b0, 0, N);
    di_en = 1'b0;
    wait_drain("b2b");
    chk("b2b_burst_len", 32'(last_run), 192);
    chk("b2b_ovf", 32'(ovf), 0);

    // Reset while frame 0 drains and frame 1 is partly written.
    send_frame(1'b0, 0, N);
    send_frame(1'b0, 0, 30);
    #2;
    reset = 1'b1;
    di_en = 1'b0;
    #1;
    chk("midrst_do_en", 32'(do_en), 0);
    chk("midrst_do_sof", 32'(do_sof), 0);
    chk("midrst_do_re", 32'(do_re), 0);
    sbq.delete();
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("postrst_no_stale", 32'(do_en), 0);
    send_frame(1'b0, 0, N);
    di_en = 1'b0;
    wait_drain("postrst");
    chk("postrst_burst_len", 32'(last_run), 64);
    chk("postrst_ovf", 32'(ovf), 0);

    // N=8 instance: back-to-back frames stay overflow-free.
    for (int k = 0; k < 24; k++) begin
      d8_en = 1'b1;
      d8_re = 16'($urandom);
      d8_im = 16'($urandom);
      @(posedge clock); #1;
    end
    d8_en = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    chk("n8_b2b_ovf", 32'(o8_ovf), 0);

    // Hold both banks full, then write: ovf rises on that edge and sticks.
    force dut8.full_q = 2'b11;
    d8_en = 1'b1;
    d8_re = 16'h1234;
    d8_im = 16'h5678;
    #1;
    chk("n8_ovf_before_write", 32'(o8_ovf), 0);
    @(posedge clock); #1;
    chk("n8_ovf_rises", 32'(o8_ovf), 1);
    d8_en = 1'b0;
    release dut8.full_q;
    repeat (20) @(posedge clock);
    #1;
    chk("n8_ovf_sticky", 32'(o8_ovf), 1);
    #2;
    rst8 = 1'b1;
    #1;
    chk("n8_ovf_reset_clears", 32'(o8_ovf), 0);
    @(posedge clock); #3;
    rst8 = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
